// File: rtl/pipelined_barrel_shifter.sv
// Fully pipelined barrel shifter (LSR/LSL/ASR/ROR), one 2^k stage per shift-amount bit.
// Define BSHIFT_STICKY_EN to build the sticky chain; otherwise out_sticky is tied to 0.
`timescale 1ns/1ps
module pipelined_barrel_shifter #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned TAG_W = 4,
  localparam int unsigned SHIFT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHIFT_W-1:0] in_amt,
  input  logic [1:0]         in_mode,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_sticky,
  output logic [TAG_W-1:0]   out_tag
);

  typedef enum logic [1:0] {
    ModeLsr = 2'b00,
    ModeLsl = 2'b01,
    ModeAsr = 2'b10,
    ModeRor = 2'b11
  } mode_e;

  localparam logic [SHIFT_W:0] WidthAmt = (SHIFT_W + 1)'(WIDTH);

  function automatic int unsigned stage_dist(input int unsigned k);
    return 32'd1 << k;
  endfunction

  // Bits a stage of distance 2^k pushes out of the LSB end.
  function automatic logic [WIDTH-1:0] low_mask(input int unsigned k);
    return {WIDTH{1'b1}} >> (WIDTH - stage_dist(k));
  endfunction

  logic               stall;
  logic [SHIFT_W-1:0] pre_amt;

  // Stage inputs (stage 0 fed from the ports, stage k from register k-1)
  logic [WIDTH-1:0]   st_data  [SHIFT_W];
  logic [SHIFT_W-1:0] st_amt   [SHIFT_W];
  mode_e              st_mode  [SHIFT_W];
  logic [TAG_W-1:0]   st_tag   [SHIFT_W];
  logic [SHIFT_W-1:0] st_valid;

  logic [WIDTH-1:0]   sh_data  [SHIFT_W];
  logic [WIDTH-1:0]   nx_data  [SHIFT_W];

  logic [WIDTH-1:0]   data_q   [SHIFT_W];
  logic [SHIFT_W-1:0] amt_q    [SHIFT_W];
  mode_e              mode_q   [SHIFT_W];
  logic [TAG_W-1:0]   tag_q    [SHIFT_W];
  logic [SHIFT_W-1:0] valid_q;

`ifdef BSHIFT_STICKY_EN
  logic [SHIFT_W-1:0] st_sticky;
  logic [SHIFT_W-1:0] nx_sticky;
  logic [SHIFT_W-1:0] sticky_q;
`endif

  assign out_valid = valid_q[SHIFT_W-1];
  assign stall     = out_valid & ~out_ready;
  assign in_ready  = ~stall;
  assign out_data  = data_q[SHIFT_W-1];
  assign out_tag   = tag_q[SHIFT_W-1];
`ifdef BSHIFT_STICKY_EN
  assign out_sticky = sticky_q[SHIFT_W-1];
`else
  assign out_sticky = 1'b0;
`endif

  // Rotation wraps modulo WIDTH; amounts are < 2*WIDTH so one subtraction suffices.
  always_comb begin
    pre_amt = in_amt;
    if ((mode_e'(in_mode) == ModeRor) && ({1'b0, in_amt} >= WidthAmt)) begin
      pre_amt = in_amt - WidthAmt[SHIFT_W-1:0];
    end
  end

  always_comb begin
    st_data[0]  = in_data;
    st_amt[0]   = pre_amt;
    st_mode[0]  = mode_e'(in_mode);
    st_tag[0]   = in_tag;
    st_valid[0] = in_valid;
    for (int unsigned k = 1; k < SHIFT_W; k++) begin
      st_data[k]  = data_q[k-1];
      st_amt[k]   = amt_q[k-1];
      st_mode[k]  = mode_q[k-1];
      st_tag[k]   = tag_q[k-1];
      st_valid[k] = valid_q[k-1];
    end
  end

  always_comb begin
    for (int unsigned k = 0; k < SHIFT_W; k++) begin
      sh_data[k] = st_data[k];
      unique case (st_mode[k])
        ModeLsr: sh_data[k] = st_data[k] >> stage_dist(k);
        ModeLsl: sh_data[k] = st_data[k] << stage_dist(k);
        // The MSB is the original sign at every stage, so it is the fill bit.
        ModeAsr: sh_data[k] = $signed(st_data[k]) >>> stage_dist(k);
        ModeRor: sh_data[k] = (st_data[k] >> stage_dist(k))
                            | (st_data[k] << (WIDTH - stage_dist(k)));
      endcase
      nx_data[k] = st_amt[k][k] ? sh_data[k] : st_data[k];
    end
  end

`ifdef BSHIFT_STICKY_EN
  always_comb begin
    st_sticky[0] = 1'b0;
    for (int unsigned k = 1; k < SHIFT_W; k++) begin
      st_sticky[k] = sticky_q[k-1];
    end
    for (int unsigned k = 0; k < SHIFT_W; k++) begin
      nx_sticky[k] = st_sticky[k]
                   | (st_amt[k][k]
                      & ((st_mode[k] == ModeLsr) | (st_mode[k] == ModeAsr))
                      & (|(st_data[k] & low_mask(k))));
    end
  end
`endif

  // Single global enable: bubbles move with valid entries, nothing is compressed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int unsigned k = 0; k < SHIFT_W; k++) begin
        data_q[k] <= '0;
        amt_q[k]  <= '0;
        mode_q[k] <= ModeLsr;
        tag_q[k]  <= '0;
      end
`ifdef BSHIFT_STICKY_EN
      sticky_q <= '0;
`endif
    end else if (!stall) begin
      for (int unsigned k = 0; k < SHIFT_W; k++) begin
        valid_q[k] <= st_valid[k];
        if (st_valid[k]) begin
          data_q[k] <= nx_data[k];
          amt_q[k]  <= st_amt[k];
          mode_q[k] <= st_mode[k];
          tag_q[k]  <= st_tag[k];
`ifdef BSHIFT_STICKY_EN
          sticky_q[k] <= nx_sticky[k];
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Scoreboard bench for pipelined_barrel_shifter (WIDTH=24, TAG_W=4): directed plus random traffic.
`timescale 1ns/1ps
module tb_pipelined_barrel_shifter;

  localparam int WIDTH   = 24;
  localparam int TAG_W   = 4;
  localparam int SHIFT_W = 5;
`ifdef BSHIFT_STICKY_EN
  localparam logic StkEn = 1'b1;
`else
  localparam logic StkEn = 1'b0;
`endif

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [SHIFT_W-1:0] in_amt;
  logic [1:0]         in_mode;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_sticky;
  logic [TAG_W-1:0]   out_tag;

  pipelined_barrel_shifter #(
    .WIDTH (WIDTH),
    .TAG_W (TAG_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_amt     (in_amt),
    .in_mode    (in_mode),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_sticky (out_sticky),
    .out_tag    (out_tag)
  );

  typedef struct {
    logic [WIDTH-1:0] d;
    logic             s;
    logic [TAG_W-1:0] t;
    int               acc_cyc;
    int               acc_stall;
  } exp_t;

  exp_t             sb[$];
  logic [WIDTH-1:0] exp_d;
  logic             exp_s;
  int               n_vec = 0;
  int               n_err = 0;
  int               cyc = 0;
  int               stall_cnt = 0;
  logic             rnd_bp = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: each output bit picks its source bit by the mode's rule.
  function automatic void model(input logic [WIDTH-1:0] d, input int a, input int m,
                                output logic [WIDTH-1:0] r, output logic s);
    int e;
    logic sign;
    sign = d[WIDTH-1];
    r = '0;
    s = 1'b0;
    e = (m == 3 && a >= WIDTH) ? a - WIDTH : a;
    for (int i = 0; i < WIDTH; i++) begin
      case (m)
        0:       r[i] = (i + a < WIDTH) ? d[i + a] : 1'b0;
        1:       r[i] = (i - a >= 0) ? d[i - a] : 1'b0;
        2:       r[i] = (i + a < WIDTH) ? d[i + a] : sign;
        default: r[i] = d[(i + e) % WIDTH];
      endcase
    end
    if (m == 0 || m == 2) begin
      for (int j = 0; j < WIDTH && j < a; j++) s = s | d[j];
    end
    if (!StkEn) s = 1'b0;
  endfunction

  // Accept side: record the expectation for every transfer.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && in_valid && in_ready) begin
      e.d = exp_d;
      e.s = exp_s;
      e.t = in_tag;
      e.acc_cyc = cyc;
      e.acc_stall = stall_cnt;
      sb.push_back(e);
    end
  end

  // Monitor: stall rule every cycle, scoreboard compare on each output transfer.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      chk("in_ready_vs_stall", 32'(in_ready), 32'(!(out_valid && !out_ready)));
      if (out_valid && !out_ready) begin
        stall_cnt++;
      end else if (out_valid) begin
        if (sb.size() == 0) begin
          chk("spurious_output", 32'(out_tag), 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          chk("out_data", 32'(out_data), 32'(e.d));
          chk("out_sticky", 32'(out_sticky), 32'(e.s));
          chk("out_tag", 32'(out_tag), 32'(e.t));
          chk("latency", 32'(cyc), 32'(e.acc_cyc + SHIFT_W + stall_cnt - e.acc_stall));
        end
      end
    end
  end

  always @(posedge clk) begin
    if (rnd_bp) begin
      #1 out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(input logic [WIDTH-1:0] d, input int a, input int m,
                      input logic [TAG_W-1:0] t, input logic [WIDTH-1:0] ed, input logic es);
    int guard;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = d;
    in_amt   = SHIFT_W'(a);
    in_mode  = 2'(m);
    in_tag   = t;
    exp_d    = ed;
    exp_s    = es;
    guard    = 0;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) chk("accept_timeout", 32'(guard), 32'd0);
  endtask

  task automatic send_rand(input logic [TAG_W-1:0] t);
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] r;
    logic s;
    int a;
    int m;
    d = WIDTH'($urandom);
    a = $urandom_range(0, 31);
    m = $urandom_range(0, 3);
    model(d, a, m, r, s);
    send(d, a, m, t, r, s);
  endtask

  task automatic idle();
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    idle();
    guard = 0;
    while (sb.size() != 0 && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 400) chk("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_sticky", 32'(out_sticky), 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_amt = '0;
    in_mode = '0;
    in_tag = '0;
    out_ready = 1'b1;
    exp_d = '0;
    exp_s = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_reset_outputs();
    @(posedge clk);
    #1 rst = 1'b0;

    // Directed vectors with hand-derived results
    send(24'h800001, 1,  0, 4'h3, 24'h400000, StkEn);
    send(24'h800000, 31, 2, 4'h4, 24'hFFFFFF, StkEn);
    send(24'h000000, 31, 0, 4'h5, 24'h000000, 1'b0);
    send(24'h000001, 23, 1, 4'h6, 24'h800000, 1'b0);
    send(24'h000001, 25, 3, 4'h7, 24'h800000, 1'b0);
    send(24'h123456, 0,  3, 4'h8, 24'h123456, 1'b0);
    send(24'h000F00, 8,  0, 4'h9, 24'h00000F, 1'b0);
    drain();

    // Streaming, tags 0-7
    for (int i = 0; i < 8; i++) send_rand(TAG_W'(i));
    drain();

    // Backpressure: hold out_ready low for 10 cycles after the first result
    fork
      begin
        for (int i = 0; i < 8; i++) send_rand(TAG_W'(i));
        idle();
      end
      begin
        for (int i = 0; i < 50 && !out_valid; i++) @(negedge clk);
        @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (10) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Reset with three operations in flight
    for (int i = 0; i < 3; i++) send_rand(TAG_W'(10 + i));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst = 1'b1;
    #1 chk_reset_outputs();
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(negedge clk);
    send(24'hABCDEF, 4, 1, 4'hE, 24'hBCDEF0, 1'b0);
    drain();

    // Random traffic with random backpressure and input gaps
    rnd_bp = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) idle();
      send_rand(TAG_W'(i));
    end
    drain();
    rnd_bp = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b1;
    repeat (SHIFT_W + 2) @(negedge clk);
    chk("final_idle", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipelined_barrel_shifter.md
# pipelined_barrel_shifter

Parametrised, fully pipelined barrel shifter for the single-precision floating-point adder datapath and later wider formats. One shift amount is applied per cycle. The block supports four modes: logical right, logical left, arithmetic right and rotate right. For right shifts it also produces a sticky bit (the OR of all bits shifted out) for guard/round/sticky rounding. It replaces the per-use fixed-width combinational shifters used for exponent alignment and normalisation. A valid/ready handshake lets the adder pipeline stall it.

## Interface
Parameters:
- WIDTH, 24, data width in bits (≥ 2).
- TAG_W, 4, width of the sideband tag carried alongside each operation.
- SHIFT_W, localparam = $clog2(WIDTH), width of the shift-amount port.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  input operation is present.
- in_ready  out  1  block accepts the input this cycle.
- in_data  in  WIDTH  operand.
- in_amt  in  SHIFT_W  shift amount.
- in_mode  in  2  00 = LSR, 01 = LSL, 10 = ASR, 11 = ROR.
- in_tag  in  TAG_W  opaque sideband, returned unchanged.
- out_valid  out  1  result is present.
- out_ready  in  1  consumer accepts the result.
- out_data  out  WIDTH  shifted result.
- out_sticky  out  1  OR of the bits discarded by an LSR/ASR shift.
- out_tag  out  TAG_W  tag of this result.

## Operation
- The pipeline has SHIFT_W stages. Stage k applies a conditional shift by 2^k, controlled by amt[k], and registers:
  - data
  - amt
  - mode
  - tag
  - running sticky
  - valid bit
- Input pre-processing, combinational, before stage 0:
  - ROR only: if in_amt ≥ WIDTH, the effective amount is in_amt − WIDTH. The result is the input rotated by amt mod WIDTH; this is exact because in_amt < 2·WIDTH.
  - LSR/LSL/ASR: amounts ≥ WIDTH are applied unmodified.
- Fill bits per mode:
  - LSR: zeros enter at the MSB. The output is 0 for amt ≥ WIDTH.
  - LSL: zeros enter at the LSB. The output is 0 for amt ≥ WIDTH.
  - ASR: copies of in_data[WIDTH−1] enter at the MSB. The output is all sign bits for amt ≥ WIDTH.
  - ROR: bits leaving the LSB re-enter at the MSB.
- Sticky:
  - Each stage ORs the bits it discards at the LSB end into the running sticky.
  - It is valid for LSR and ASR.
  - It is forced to 0 for LSL and ROR.
- Flow control is a single global stall:
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall.
  - While stalled, every stage register holds its value.
  - Otherwise all stages advance one position, including bubbles.
- An input transfers when in_valid & in_ready. A result transfers when out_valid & out_ready.
- Bubbles advance but are not compressed. Capacity is SHIFT_W results in flight.
- Results leave in acceptance order.
- in_data/in_amt/in_mode/in_tag are sampled only on transfer. When in_valid = 0, a bubble enters the pipeline.

## Timing
- Latency: a result is presented SHIFT_W cycles after its accepting edge, provided no stall occurs in between. For WIDTH = 24 this is 5 cycles.
- Throughput: one operation per cycle while out_ready = 1.
- in_ready depends combinationally on out_ready; there is no skid buffer.
- Reset (asynchronous, any time): all stage valid bits clear to 0 immediately. Data, tag and sticky registers clear to 0. Reset values:
  - out_valid = 0
  - out_data = 0
  - out_sticky = 0
  - out_tag = 0
  - in_ready = 1
- In-flight operations are discarded with no partial outputs. The first input can be accepted on the first rising edge after rst deasserts.
- Simultaneous input transfer and output transfer in the same cycle is legal, and both complete.
- Stall entered while the pipeline is partially full: bubbles are held in place like valid entries.

## Configuration
- BSHIFT_STICKY_EN
  - Defined: the sticky chain exists and out_sticky behaves as specified.
  - Undefined: no sticky registers are built and out_sticky is tied to 0. All other behaviour and latency are unchanged.

## Test plan
All scenarios use WIDTH = 24 and TAG_W = 4.
- LSR: in_data 0x800001, amt 1, tag 0x3 → after 5 cycles, out_data 0x400000, out_sticky 1 (0 if BSHIFT_STICKY_EN is undefined), out_tag 0x3.
- ASR/LSR saturation: ASR 0x800000, amt 31 → 0xFFFFFF, sticky 1. LSR 0x000000, amt 31 → 0x000000, sticky 0.
- LSL and ROR: LSL 0x000001, amt 23 → 0x800000, sticky 0. ROR 0x000001, amt 25 → 0x800000 (effective amount 1). ROR 0x123456, amt 0 → 0x123456.
- Streaming: 8 back-to-back ops with tags 0–7, out_ready = 1 → 8 consecutive out_valid cycles starting 5 cycles after the first accept, tags in order 0–7.
- Backpressure: same stream, out_ready held 0 for 10 cycles after the first result appears → in_ready = 0 during the hold, no result lost or duplicated, order preserved.
- Reset mid-stream: assert rst for 1 cycle with 3 ops in flight → out_valid falls immediately, none of the 3 results ever appears, and a new op issued after reset returns after 5 cycles.
